// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control decoder and multiply/divide sequencer.
//   - R-type function codes
//   - alu_op_e: 4-bit ALU operation codes (zero-extended to ALU_OP_W at the top)
//   - WB_* : writeback source select values
//   - state_e : sequencer FSM states
package alu_ctrl_pkg;

  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_ADDU  = 6'b100001;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_SUBU  = 6'b100011;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_XOR   = 6'b100110;
  localparam logic [5:0] FUNC_NOR   = 6'b100111;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_SLTU  = 6'b101011;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_NOR  = 4'b0100,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000
  } alu_op_e;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_HI  = 2'b01;
  localparam logic [1:0] WB_LO  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath: one shift-add (multiply) or restoring
// (divide) step per cycle for WIDTH cycles, on operand magnitudes, with the
// sign fix-up applied to the final step's result.
// Ports:
//   clk, rst          clock, async active-high reset
//   start             capture a/b and begin (one cycle)
//   is_div, is_signed operation select, sampled with start
//   a, b              dividend/multiplicand and divisor/multiplier
//   done              high during the last iteration; hi_res/lo_res valid then
//   hi_res, lo_res    signed-corrected result (HI=upper/remainder, LO=lower/quotient)
//   dz                captured divisor was zero (meaningful with done)
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res,
  output logic             dz
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             busy_q;
  logic             div_q;
  logic             neg_q;      // product/quotient needs negating
  logic             rem_neg_q;  // dividend was negative
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0] upper_q;    // partial product high / partial remainder
  logic [WIDTH-1:0] lower_q;    // multiplier / quotient shift register

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff, upper_d, lower_d;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  always_comb begin
    mul_sum   = {1'b0, upper_q} + (lower_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {upper_q, lower_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mcand_q};
    // The remainder stays below the divisor, so the difference fits WIDTH bits.
    div_diff  = div_shift[WIDTH-1:0] - mcand_q;
    if (div_q) begin
      upper_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lower_d = {lower_q[WIDTH-2:0], div_ge};
    end else begin
      upper_d = mul_sum[WIDTH:1];
      lower_d = {mul_sum[0], lower_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      upper_q   <= '0;
      lower_q   <= '0;
    end else if (start) begin
      busy_q    <= 1'b1;
      div_q     <= is_div;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      cnt_q     <= '0;
      mcand_q   <= b_mag;
      upper_q   <= '0;
      lower_q   <= a_mag;
    end else if (busy_q) begin
      upper_q <= upper_d;
      lower_q <= lower_d;
      if (done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign done = busy_q & (cnt_q == CNT_LAST);

  // Result is taken from the last step's next values so the top can load
  // HI/LO on the same edge that leaves RUN.
  always_comb begin
    prod     = {upper_d, lower_d};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    quot_fix = neg_q ? (~lower_d + 1'b1) : lower_d;
    rem_fix  = rem_neg_q ? (~upper_d + 1'b1) : upper_d;
    dz       = div_q & (mcand_q == '0);
    if (div_q) begin
      // With a zero divisor the remainder path already reproduces the dividend.
      hi_res = rem_fix;
      lo_res = dz ? '1 : quot_fix;
    end else begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_muldiv_controller.sv
// ALU control decoder with an iterative MULT/DIV sequencer and HI/LO registers.
// Ports:
//   clk, rst        clock, async active-high reset
//   alu_case, func  main-control class and R-type function field
//   op_valid        instruction in decode is valid
//   src_a, src_b    rs / rt operands
//   alu_op          ALU operation code
//   wb_sel          writeback select: 00 ALU, 01 HI, 10 LO
//   hilo_data       HI or LO per wb_sel, else 0
//   stall           hold PC/IR while a MULT/DIV runs
//   illegal_op      unrecognised R-type func with op_valid
//   div_by_zero     one-cycle pulse when a divide by zero retires
//   hi, lo          HI / LO registers
//
// state | meaning
// IDLE  | waiting; a valid MULT/DIV is captured and stalls this same cycle
// RUN   | one datapath step per cycle, WIDTH cycles, stall held
// DONE  | HI/LO hold the result, stall released so the instruction retires
module alu_muldiv_controller
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ALU_OP_W  = 4,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          alu_case,
  input  logic [5:0]          func,
  input  logic                op_valid,
  input  logic [WIDTH-1:0]    src_a,
  input  logic [WIDTH-1:0]    src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          wb_sel,
  output logic [WIDTH-1:0]    hilo_data,
  output logic                stall,
  output logic                illegal_op,
  output logic                div_by_zero,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo
);

  alu_op_e    op_sel;
  logic [1:0] wb_sel_dec;
  logic       md_req, md_div, md_signed;

  always_comb begin
    op_sel     = ALU_ADD;
    wb_sel_dec = WB_ALU;
    illegal_op = 1'b0;
    md_req     = 1'b0;
    md_div     = 1'b0;
    md_signed  = 1'b0;
    case (alu_case)
      2'b00: op_sel = ALU_ADD;
      2'b01: op_sel = ALU_SUB;
      2'b11: op_sel = ALU_AND;
      default: begin
        case (func)
          FUNC_AND:             op_sel = ALU_AND;
          FUNC_OR:              op_sel = ALU_OR;
          FUNC_ADD, FUNC_ADDU:  op_sel = ALU_ADD;
          FUNC_SUB, FUNC_SUBU:  op_sel = ALU_SUB;
          FUNC_XOR:             op_sel = ALU_XOR;
          FUNC_NOR:             op_sel = ALU_NOR;
          FUNC_SLT:             op_sel = ALU_SLT;
          FUNC_SLTU:            op_sel = ALU_SLTU;
          FUNC_MFHI: begin
            if (MULDIV_EN) wb_sel_dec = WB_HI;
            else           illegal_op = op_valid;
          end
          FUNC_MFLO: begin
            if (MULDIV_EN) wb_sel_dec = WB_LO;
            else           illegal_op = op_valid;
          end
          FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: begin
            if (MULDIV_EN) begin
              // func[1] separates DIV from MULT, func[0] marks the unsigned form.
              md_req    = 1'b1;
              md_div    = func[1];
              md_signed = ~func[0];
            end else begin
              illegal_op = op_valid;
            end
          end
          default: illegal_op = op_valid;
        endcase
      end
    endcase
  end

  assign alu_op = ALU_OP_W'(op_sel);
  assign wb_sel = wb_sel_dec;

  always_comb begin
    case (wb_sel)
      WB_HI:   hilo_data = hi;
      WB_LO:   hilo_data = lo;
      default: hilo_data = '0;
    endcase
  end

  generate
    if (MULDIV_EN) begin : g_muldiv
      state_e           state_q, state_d;
      logic             start, done, dz, dz_q;
      logic [WIDTH-1:0] hi_res, lo_res, hi_q, lo_q;

      // rst gates start so stall drops as soon as reset is asserted, even
      // though the held instruction still presents a MULT/DIV.
      assign start = op_valid & md_req & (state_q == ST_IDLE) & ~rst;

      muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .is_div   (md_div),
        .is_signed(md_signed),
        .a        (src_a),
        .b        (src_b),
        .done     (done),
        .hi_res   (hi_res),
        .lo_res   (lo_res),
        .dz       (dz)
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
      end

      always_comb begin
        state_d = state_q;
        case (state_q)
          ST_IDLE: if (start) state_d = ST_RUN;
          ST_RUN:  if (done)  state_d = ST_DONE;
          default: state_d = ST_IDLE;
        endcase
      end

      always_comb begin
        stall = ~rst & (start | (state_q == ST_RUN));
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hi_q <= '0;
          lo_q <= '0;
          dz_q <= 1'b0;
        end else begin
          dz_q <= done & dz;
          if (done) begin
            hi_q <= hi_res;
            lo_q <= lo_res;
          end
        end
      end

      assign hi          = hi_q;
      assign lo          = lo_q;
      assign div_by_zero = dz_q;
    end else begin : g_no_muldiv
      assign stall       = 1'b0;
      assign hi          = '0;
      assign lo          = '0;
      assign div_by_zero = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_alu_muldiv_controller.sv
module tb_alu_muldiv_controller;

  localparam int W = 32;

  logic         clk, rst;
  logic [1:0]   alu_case;
  logic [5:0]   func;
  logic         op_valid;
  logic [W-1:0] src_a, src_b;
  logic [3:0]   alu_op;
  logic [1:0]   wb_sel;
  logic [W-1:0] hilo_data, hi, lo;
  logic         stall, illegal_op, div_by_zero;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  logic [5:0] known_f [16] = '{6'b100100, 6'b100101, 6'b100000, 6'b100001,
                               6'b100010, 6'b100011, 6'b100110, 6'b100111,
                               6'b101010, 6'b101011, 6'b010000, 6'b010010,
                               6'b011000, 6'b011001, 6'b011010, 6'b011011};
  logic [3:0] known_op [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0110,
                                4'b0110, 4'b0011, 4'b0100, 4'b0111, 4'b1000};
  logic [5:0] md_f [4] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011};

  alu_muldiv_controller #(.WIDTH(W), .ALU_OP_W(4), .MULDIV_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_case   (alu_case),
    .func       (func),
    .op_valid   (op_valid),
    .src_a      (src_a),
    .src_b      (src_b),
    .alu_op     (alu_op),
    .wb_sel     (wb_sel),
    .hilo_data  (hilo_data),
    .stall      (stall),
    .illegal_op (illegal_op),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decode reference straight from the opcode table.
  task automatic ref_decode(input logic [1:0] ac, input logic [5:0] f, input logic v,
                            output logic [3:0] op, output logic [1:0] wb,
                            output logic ill, output logic md);
    op = 4'b0010; wb = 2'b00; ill = 1'b0; md = 1'b0;
    if (ac == 2'b01) op = 4'b0110;
    else if (ac == 2'b11) op = 4'b0000;
    else if (ac == 2'b10) begin
      case (f)
        6'b100100: op = 4'b0000;
        6'b100101: op = 4'b0001;
        6'b100000, 6'b100001: op = 4'b0010;
        6'b100010, 6'b100011: op = 4'b0110;
        6'b100110: op = 4'b0011;
        6'b100111: op = 4'b0100;
        6'b101010: op = 4'b0111;
        6'b101011: op = 4'b1000;
        6'b010000: wb = 2'b01;
        6'b010010: wb = 2'b10;
        6'b011000, 6'b011001, 6'b011010, 6'b011011: md = 1'b1;
        default: ill = v;
      endcase
    end
  endtask

  // Arithmetic reference using 64-bit integer math.
  task automatic ref_muldiv(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint sa, sb;
    logic [63:0] p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    p  = '0;
    if ((f == 6'b011010 || f == 6'b011011) && b == 32'd0) begin
      dz = 1'b1;
      p  = {a, 32'hFFFF_FFFF};
    end else begin
      case (f)
        6'b011000: p = sa * sb;
        6'b011001: p = {32'd0, a} * {32'd0, b};
        6'b011010: begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
        default: p = {a % b, a / b};
      endcase
    end
    h = p[63:32];
    l = p[31:0];
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    logic edz, dz_early;
    int n;
    ref_muldiv(f, a, b, eh, el, edz);
    @(negedge clk);
    alu_case = 2'b10; func = f; op_valid = 1'b1; src_a = a; src_b = b;
    #1;
    n = 0;
    dz_early = 1'b0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      if (div_by_zero !== 1'b0) dz_early = 1'b1;
      @(negedge clk);
      #1;
    end
    check({tag, " stall_cycles"}, 64'(n), 64'd33);
    check({tag, " dz_in_stall"}, 64'(dz_early), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    check({tag, " dz_pulse"}, 64'(div_by_zero), 64'(edz));
    exp_hi = eh;
    exp_lo = el;
    @(negedge clk);
    op_valid = 1'b0; func = 6'b100000;
    #1;
    check({tag, " dz_after"}, 64'(div_by_zero), 64'd0);
    check({tag, " stall_after"}, 64'(stall), 64'd0);
  endtask

  task automatic run_decode(input logic [1:0] ac, input logic [5:0] f, input logic v);
    logic [3:0] eop;
    logic [1:0] ewb;
    logic eill, emd, vv;
    logic [W-1:0] ehd;
    vv = v;
    ref_decode(ac, f, vv, eop, ewb, eill, emd);
    if (emd) vv = 1'b0;  // keep the sequencer idle during the decode sweep
    @(negedge clk);
    alu_case = ac; func = f; op_valid = vv;
    #1;
    ehd = (ewb == 2'b01) ? exp_hi : (ewb == 2'b10) ? exp_lo : '0;
    check("dec alu_op", 64'(alu_op), 64'(eop));
    check("dec wb_sel", 64'(wb_sel), 64'(ewb));
    check("dec illegal", 64'(illegal_op), 64'(eill));
    check("dec stall", 64'(stall), 64'd0);
    check("dec hilo_data", 64'(hilo_data), 64'(ehd));
  endtask

  initial begin
    logic [5:0] f;
    logic [31:0] a, b;
    rst = 1'b1; alu_case = 2'b00; func = 6'd0; op_valid = 1'b0; src_a = '0; src_b = '0;
    #1;
    check("rst stall", 64'(stall), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst dz", 64'(div_by_zero), 64'd0);
    check("rst wb_sel", 64'(wb_sel), 64'd0);
    check("rst alu_op", 64'(alu_op), 64'h2);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed decode sweep.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      alu_case = 2'b10; func = known_f[i]; op_valid = 1'b1;
      #1;
      check("sweep alu_op", 64'(alu_op), 64'(known_op[i]));
      check("sweep illegal", 64'(illegal_op), 64'd0);
    end
    run_decode(2'b10, 6'b111111, 1'b1);
    run_decode(2'b10, 6'b111111, 1'b0);
    run_decode(2'b00, 6'b011000, 1'b1);
    run_decode(2'b01, 6'b111111, 1'b1);
    run_decode(2'b11, 6'b100101, 1'b1);

    // Directed arithmetic cases.
    run_op("mult", 6'b011000, 32'hFFFF_FFFD, 32'd7);
    run_op("multu", 6'b011001, 32'hFFFF_FFFD, 32'd7);
    run_op("div", 6'b011010, 32'hFFFF_FFF9, 32'd2);
    run_op("divu", 6'b011011, 32'd7, 32'd2);
    run_op("div_ovf", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_z", 6'b011011, 32'd5, 32'd0);
    run_op("div_z_neg", 6'b011010, 32'hFFFF_FF00, 32'd0);

    // MFLO then MFHI after a MULT; no new stall window.
    run_op("mult2", 6'b011000, 32'h1234_5678, 32'hFEDC_BA98);
    @(negedge clk);
    alu_case = 2'b10; func = 6'b010010; op_valid = 1'b1;
    #1;
    check("mflo wb_sel", 64'(wb_sel), 64'd2);
    check("mflo data", 64'(hilo_data), 64'(exp_lo));
    check("mflo stall", 64'(stall), 64'd0);
    @(negedge clk);
    func = 6'b010000;
    #1;
    check("mfhi wb_sel", 64'(wb_sel), 64'd1);
    check("mfhi data", 64'(hilo_data), 64'(exp_hi));
    check("mfhi stall", 64'(stall), 64'd0);
    @(negedge clk);
    #1;
    check("mfhi stall2", 64'(stall), 64'd0);
    op_valid = 1'b0;

    // Reset in the middle of a run (counter = 10).
    @(negedge clk);
    alu_case = 2'b10; func = 6'b011000; op_valid = 1'b1; src_a = 32'd9; src_b = 32'd11;
    repeat (11) @(negedge clk);
    #1;
    check("pre_rst stall", 64'(stall), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst stall", 64'(stall), 64'd0);
    check("mid_rst hi", 64'(hi), 64'd0);
    check("mid_rst lo", 64'(lo), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 6'b011000, 32'hFFFF_FFF0, 32'h0000_0003);

    // Randomized decode.
    for (int i = 0; i < 40; i++) begin
      f = (i % 2 == 1) ? known_f[$urandom_range(0, 15)] : 6'($urandom);
      run_decode(2'($urandom_range(0, 3)), f, 1'($urandom_range(0, 1)));
    end

    // Randomized multiply/divide.
    for (int i = 0; i < 24; i++) begin
      f = md_f[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: ;
      endcase
      run_op("rand", f, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
